filter_output_decimator: RTL and testbench

FILTER_OUTPUT_DECIMATOR -- requirements
Module: filter_output_decimator

---
 rtl/filter_output_decimator.sv | 146 ++++++++++++++
 tb/tb_filter_output_decimator.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_output_decimator.sv
// Integrate-and-dump decimator by 2^LOG2_DECIM with round-half-up, saturation and an output FIFO.
// Results are pushed one edge after the completing sample; overflow drops results and is sticky.
module filter_output_decimator #(
  parameter int unsigned LOG2_DECIM      = 2,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       Clk_i,
  input  logic                       Rst_i,
  input  logic [17:0]                Data_i,
  input  logic                       DataNd_i,
  input  logic                       Ready_i,
  output logic [17:0]                Data_o,
  output logic                       DataValid_o,
  output logic [FIFO_DEPTH_LOG2:0]   Count_o,
  output logic                       Overflow_o
);

  localparam int unsigned AccW   = 18 + LOG2_DECIM;
  localparam int unsigned PtrW   = FIFO_DEPTH_LOG2;
  localparam int unsigned CountW = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned Depth  = 2 ** FIFO_DEPTH_LOG2;

  localparam logic [LOG2_DECIM-1:0] PhaseLast = '1;
  localparam logic signed [AccW:0]  Half      = (AccW + 1)'(2 ** (LOG2_DECIM - 1));

  // Accumulator and phase
  logic signed [AccW-1:0]     acc_q, acc_d;
  logic        [LOG2_DECIM-1:0] phase_q, phase_d;
  logic                       pend_q, pend_d;
  logic        [17:0]         res_q, res_d;

  logic signed [AccW-1:0]     sum;
  logic signed [AccW:0]       rnd_sum;
  logic signed [AccW:0]       rnd_shift;
  logic        [AccW-17:0]    rnd_top;
  logic        [17:0]         sat_res;

  // FIFO
  logic [17:0]       mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [17:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic pop, push, full, drop;

  assign sum       = acc_q + $signed({{LOG2_DECIM{Data_i[17]}}, Data_i});
  assign rnd_sum   = $signed({sum[AccW-1], sum}) + Half;
  assign rnd_shift = rnd_sum >>> LOG2_DECIM;
  assign rnd_top   = rnd_shift[AccW:17];

  // In range when all bits from bit 17 upward are copies of the sign.
  always_comb begin
    if ((&rnd_top) || !(|rnd_top)) begin
      sat_res = rnd_shift[17:0];
    end else if (rnd_shift[AccW]) begin
      sat_res = 18'h20000;
    end else begin
      sat_res = 18'h1FFFF;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    pend_d  = 1'b0;
    res_d   = res_q;
    if (DataNd_i) begin
      phase_d = phase_q + 1'b1;
      if (phase_q == PhaseLast) begin
        acc_d  = '0;
        pend_d = 1'b1;
        res_d  = sat_res;
      end else begin
        acc_d = sum;
      end
    end
  end

  assign pop  = valid_q & Ready_i;
  assign full = (count_q == CountW'(Depth));
  assign push = pend_q & (~full | pop);
  assign drop = pend_q & full & ~pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    // Head register bypasses the write when the pushed entry becomes the new head.
    data_d = data_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        data_d = res_q;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end
    valid_d = (count_d != '0);
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      acc_q    <= '0;
      phase_q  <= '0;
      pend_q   <= 1'b0;
      res_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      res_q    <= res_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (!Rst_i && push) begin
      mem_q[wr_ptr_q] <= res_q;
    end
  end

  assign Data_o      = data_q;
  assign DataValid_o = valid_q;
  assign Count_o     = count_q;
  assign Overflow_o  = ovf_q;

endmodule

// File: tb/tb_filter_output_decimator.sv
// Bench for filter_output_decimator: directed scenarios plus randomized traffic against a
// queue-based reference model of the decimator and its output FIFO.
module tb_filter_output_decimator;

  localparam int LOG2_DECIM      = 2;
  localparam int FIFO_DEPTH_LOG2 = 3;
  localparam int DECIM           = 1 << LOG2_DECIM;
  localparam int DEPTH           = 1 << FIFO_DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nd = 1'b0;
  logic        rdy = 1'b0;
  logic [17:0] din = '0;
  logic [17:0] dout;
  logic        dvalid;
  logic [3:0]  count;
  logic        ovf;

  always #5 clk = ~clk;

  filter_output_decimator #(
    .LOG2_DECIM      (LOG2_DECIM),
    .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) dut (
    .Clk_i       (clk),
    .Rst_i       (rst),
    .Data_i      (din),
    .DataNd_i    (nd),
    .Ready_i     (rdy),
    .Data_o      (dout),
    .DataValid_o (dvalid),
    .Count_o     (count),
    .Overflow_o  (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_fifo[$];
  int          m_sum;
  int          m_nsamp;
  bit          m_pend;
  int          m_pend_val;
  bit          m_ovf;
  logic [17:0] m_data;

  // Block average rounded half toward +inf, then clamped to 18-bit signed range.
  function automatic int ref_result(input int s);
    int r;
    int q;
    r = s + DECIM / 2;
    if (r >= 0) q = r / DECIM;
    else q = -((-r + DECIM - 1) / DECIM);
    if (q > 131071) q = 131071;
    if (q < -131072) q = -131072;
    return q;
  endfunction

  function automatic void model_edge(input logic r, input logic n, input logic [17:0] d,
                                     input logic y);
    if (r) begin
      m_fifo.delete();
      m_sum = 0;
      m_nsamp = 0;
      m_pend = 0;
      m_ovf = 0;
      m_data = '0;
      return;
    end
    if (y && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (m_pend) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend_val);
      else m_ovf = 1;
    end
    m_pend = 0;
    if (n) begin
      m_sum += int'($signed(d));
      m_nsamp++;
      if (m_nsamp == DECIM) begin
        m_pend = 1;
        m_pend_val = ref_result(m_sum);
        m_sum = 0;
        m_nsamp = 0;
      end
    end
    if (m_fifo.size() > 0) m_data = 18'(m_fifo[0]);
  endfunction

  task automatic tick(input logic r, input logic n, input logic [17:0] d, input logic y);
    rst = r;
    nd = n;
    din = d;
    rdy = y;
    @(posedge clk);
    model_edge(r, n, d, y);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 18'h1FFFF, 1'b1);
    tick(1'b1, 1'b1, 18'h1FFFF, 1'b1);
    n_checks++; if (dout !== 18'h0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", dout); end
    n_checks++; if (dvalid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", dvalid); end
    n_checks++; if (count !== 4'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++;
      $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_constant();
    int nvalid;
    bit exp_v;
    nvalid = 0;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 18'h1FFFF, 1'b1);
      exp_v = (i >= 4) && (i % 4 == 0);
      if (dvalid === 1'b1) nvalid++;
      n_checks++; if (dvalid !== exp_v) begin n_fail++;
        $display("FAIL const_valid[%0d]: got %b want %b", i, dvalid, exp_v); end
      if (exp_v) begin
        n_checks++; if (dout !== 18'h1FFFF) begin n_fail++;
          $display("FAIL const_data[%0d]: got %h want 1ffff", i, dout); end
      end
    end
    n_checks++; if (nvalid != 3) begin n_fail++;
      $display("FAIL const_pulses: got %0d want 3", nvalid); end
  endtask

  task automatic test_rounding();
    logic [17:0] pats [12];
    logic [17:0] exps [3];
    pats = '{18'h3FFFD, 18'h3FFFD, 18'h3FFFD, 18'h3FFFE,
             18'h00001, 18'h00001, 18'h00000, 18'h00000,
             18'h00001, 18'h00000, 18'h00000, 18'h00000};
    exps = '{18'h3FFFD, 18'h00001, 18'h00000};
    for (int p = 0; p < 3; p++) begin
      tick(1'b1, 1'b0, '0, 1'b0);
      for (int j = 0; j < 4; j++) tick(1'b0, 1'b1, pats[p*4+j], 1'b0);
      n_checks++; if (dvalid !== 1'b0) begin n_fail++;
        $display("FAIL round_early[%0d]: got %b want 0", p, dvalid); end
      tick(1'b0, 1'b0, '0, 1'b0);
      n_checks++; if (dvalid !== 1'b1 || dout !== exps[p]) begin n_fail++;
        $display("FAIL round_data[%0d]: got v=%b %h want v=1 %h", p, dvalid, dout, exps[p]); end
      tick(1'b0, 1'b0, '0, 1'b1);
      n_checks++; if (dvalid !== 1'b0 || dout !== exps[p]) begin n_fail++;
        $display("FAIL round_hold[%0d]: got v=%b %h want v=0 %h", p, dvalid, dout, exps[p]); end
    end
  endtask

  task automatic test_overflow();
    int res [9];
    int s;
    logic [17:0] d;
    tick(1'b1, 1'b0, '0, 1'b0);
    s = 0;
    for (int i = 0; i < 36; i++) begin
      d = 18'($urandom);
      s += int'($signed(d));
      if (i % 4 == 3) begin res[i/4] = ref_result(s); s = 0; end
      tick(1'b0, 1'b1, d, 1'b0);
    end
    tick(1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (count !== 4'd8) begin n_fail++;
      $display("FAIL ovf_count: got %0d want 8", count); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++;
      $display("FAIL ovf_flag: got %b want 1", ovf); end
    for (int r = 0; r < 8; r++) begin
      n_checks++; if (dvalid !== 1'b1 || dout !== 18'(res[r])) begin n_fail++;
        $display("FAIL ovf_pop[%0d]: got v=%b %h want v=1 %h", r, dvalid, dout, 18'(res[r])); end
      tick(1'b0, 1'b0, '0, 1'b1);
    end
    n_checks++; if (dvalid !== 1'b0 || count !== 4'd0 || dout !== 18'(res[7])) begin n_fail++;
      $display("FAIL ovf_drained: got v=%b c=%0d %h want v=0 c=0 %h", dvalid, count, dout,
               18'(res[7])); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_full_push_pop();
    int res [9];
    int s;
    logic [17:0] d;
    tick(1'b1, 1'b0, '0, 1'b0);
    s = 0;
    for (int i = 0; i < 36; i++) begin
      d = 18'($urandom_range(0, 4095)) - 18'd2048;
      s += int'($signed(d));
      if (i % 4 == 3) begin res[i/4] = ref_result(s); s = 0; end
      tick(1'b0, 1'b1, d, 1'b0);
      if (i == 31) begin
        tick(1'b0, 1'b0, '0, 1'b0);
        n_checks++; if (count !== 4'd8 || ovf !== 1'b0) begin n_fail++;
          $display("FAIL full_fill: got c=%0d o=%b want c=8 o=0", count, ovf); end
      end
    end
    tick(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (count !== 4'd8 || ovf !== 1'b0) begin n_fail++;
      $display("FAIL full_pushpop: got c=%0d o=%b want c=8 o=0", count, ovf); end
    for (int r = 1; r < 9; r++) begin
      n_checks++; if (dvalid !== 1'b1 || dout !== 18'(res[r])) begin n_fail++;
        $display("FAIL full_order[%0d]: got v=%b %h want v=1 %h", r, dvalid, dout,
                 18'(res[r])); end
      tick(1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_block();
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b1, 18'd100, 1'b0);
    tick(1'b0, 1'b1, 18'd100, 1'b0);
    tick(1'b1, 1'b1, 18'd100, 1'b1);
    n_checks++; if (dout !== '0 || dvalid !== 1'b0 || count !== '0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_during: got %h v=%b c=%0d o=%b want all 0", dout, dvalid, count, ovf);
    end
    tick(1'b0, 1'b1, 18'd4, 1'b0);
    n_checks++; if (dout !== '0 || dvalid !== 1'b0 || count !== '0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: got %h v=%b c=%0d o=%b want all 0", dout, dvalid, count, ovf);
    end
    for (int j = 0; j < 3; j++) tick(1'b0, 1'b1, 18'd4, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (dvalid !== 1'b1 || dout !== 18'd4 || count !== 4'd1) begin n_fail++;
      $display("FAIL midrst_result: got v=%b %h c=%0d want v=1 4 c=1", dvalid, dout, count); end
  endtask

  task automatic test_gapped();
    int gap;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, 1'b1, 18'd8, 1'b0);
      if (j < 3) begin
        gap = int'($urandom_range(0, 5));
        for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 18'($urandom), 1'b0);
      end
    end
    n_checks++; if (dvalid !== 1'b0) begin n_fail++;
      $display("FAIL gap_early: got %b want 0", dvalid); end
    tick(1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (dvalid !== 1'b1 || dout !== 18'd8) begin n_fail++;
      $display("FAIL gap_result: got v=%b %h want v=1 8", dvalid, dout); end
  endtask

  task automatic test_random();
    logic        r, n, y;
    logic [17:0] d;
    int          rdy_pct;
    int          cnt_exp;
    rdy_pct = 50;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) rdy_pct = int'($urandom_range(0, 100));
      r = ($urandom_range(0, 399) == 0);
      n = ($urandom_range(0, 99) < 70);
      y = ($urandom_range(0, 99) < rdy_pct);
      d = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, 63)) - 18'd32;
      tick(r, n, d, y);
      cnt_exp = m_fifo.size();
      n_checks++; if (dvalid !== (cnt_exp > 0)) begin n_fail++;
        $display("FAIL rand_valid@%0d: got %b want %b", c, dvalid, cnt_exp > 0); end
      n_checks++; if (count !== 4'(cnt_exp)) begin n_fail++;
        $display("FAIL rand_count@%0d: got %0d want %0d", c, count, cnt_exp); end
      n_checks++; if (dout !== m_data) begin n_fail++;
        $display("FAIL rand_data@%0d: got %h want %h", c, dout, m_data); end
      n_checks++; if (ovf !== m_ovf) begin n_fail++;
        $display("FAIL rand_ovf@%0d: got %b want %b", c, ovf, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_rounding();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_block();
    test_gapped();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
